ascon_permutation_core: RTL and testbench
=========================================

Name: ascon_permutation_core

Overview:
Iterative Ascon-p permutation engine with a parametrised number of rounds unrolled per clock.
- Supports any round count 1..12 per request, selected at runtime (p12 / p8 / p6 and shorter counts).
- Sits beneath the Ascon mode controller, which loads a 320-bit state, starts a run and collects the permuted state.
- Successor to the single-round combinational round datapath: adds sequencing, a runtime round count, a handshake and an abort.

Parameters:
- UNROLL, 1, rounds computed per clock cycle; legal 1..12.
- MAX_ROUNDS, 12, highest legal round index count; fixed at 12 for Ascon-p; rounds_i is clamped to it.

Ports:
- clock_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request; accepted only when ready_o=1.
- abort_i  input  1  synchronous cancel of a run in progress.
- rounds_i  input  4  round count N, sampled at accept; 0 or >12 is treated as 12.
- state_i  input  320 (type_state, 5x64)  input state, sampled at accept.
- ready_o  output  1  idle, able to accept start_i.
- busy_o  output  1  run in progress (equals not ready_o).
- done_o  output  1  one-cycle pulse: state_o holds the finished result.
- rounds_done_o  output  4  rounds applied so far in the current/last run.
- state_o  output  320 (type_state)  state register, valid when done_o=1 and held until the next accept.

Behaviour:
- Reset (async, reset_i=1):
  - FSM=IDLE; state register=0.
  - ready_o=1, busy_o=0, done_o=0, rounds_done_o=0.
  - Reset mid-run discards the run immediately.
- FSM states: IDLE and RUN.
- Accept (IDLE, start_i=1, abort_i=0):
  - Register state_i.
  - N_eff = clamp(rounds_i).
  - remaining=N_eff.
  - idx=12-N_eff.
  - rounds_done_o=0.
  - Go to RUN. ready_o drops the next cycle.
- RUN, each cycle:
  - Apply k=min(UNROLL, remaining) chained rounds to the state register.
  - Stage j (j<k) uses constant index idx+j.
  - Stages j>=k are bypassed (pass-through).
  - remaining-=k; idx+=k; rounds_done_o+=k.
  - If remaining becomes 0: go to IDLE and assert done_o for exactly one cycle (registered, coincident with ready_o=1).
- Round definition, in order:
  - Constant add: x2 ^= {56'd0, (15-i)<<4 | i}, where i = round index 0..11.
  - 5-bit Ascon S-box on each of 64 bit-columns.
  - Linear diffusion:
    - x0: rotations 19, 28
    - x1: rotations 61, 39
    - x2: rotations 1, 6
    - x3: rotations 10, 17
    - x4: rotations 7, 41
- Latency:
  - done_o is high ceil(N_eff/UNROLL) cycles after the accept edge.
  - Throughput is one run per ceil(N_eff/UNROLL) cycles.
  - Back-to-back runs: start_i may be high in the done_o cycle and is accepted.
- start_i while busy is ignored (no queuing).
- Abort:
  - abort_i in RUN: return to IDLE next cycle; no done_o; state register not updated in that cycle.
  - rounds_done_o shows the partial count after an abort.
  - abort_i in IDLE has no effect; abort_i has priority over start_i in the same cycle.
- Outputs:
  - state_o is the state register directly.
  - state_o is undefined-for-use except in and after the done_o cycle.
  - state_o is stable until the next accept.
- Round count arithmetic:
  - idx never exceeds 12.
  - The final pass masks surplus stages, so any UNROLL works with any N.

Test Plan:
1. UNROLL=1, rounds_i=12, state_i=0, start_i pulse → done_o exactly 12 cycles later; state_o equals golden Ascon-p12(0); rounds_done_o=12.
2. UNROLL=1, rounds_i=1, state_i=0 → done_o after 1 cycle; constant 0x4b applied (index 11); state_o matches model single round.
3. UNROLL=4 vs UNROLL=1 with the same random state and rounds_i=6 → UNROLL=4 done after 2 cycles (4+2 masked), UNROLL=1 after 6; state_o identical and equal to model p6.
4. rounds_i=0 and rounds_i=15 → both behave as 12 rounds (first constant 0xf0); result equals case 1.
5. abort_i asserted on the 5th RUN cycle (UNROLL=1, N=12) → no done_o, ready_o=1 next cycle, rounds_done_o=4; start_i during RUN ignored; start_i in the done_o cycle accepted back-to-back.
6. reset_i asserted asynchronously mid-run → outputs immediately ready_o=1, done_o=0, state_o=0, rounds_done_o=0.

Source files
------------

// File: rtl/ascon_permutation_core.sv
// Iterative Ascon-p permutation engine. A run of 1..12 rounds is loaded,
// sequenced UNROLL rounds per clock, and returned in the state register.
// Surplus stages of the last pass are bypassed so any UNROLL fits any N.
module ascon_permutation_core #(
    parameter int unsigned UNROLL     = 1,
    parameter int unsigned MAX_ROUNDS = 12
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [3:0]       rounds_i,
    input  logic [4:0][63:0] state_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       rounds_done_o,
    output logic [4:0][63:0] state_o
);

    typedef logic [4:0][63:0] type_state;
    typedef enum logic {StIdle, StRun} fsm_e;

    localparam logic [3:0] MaxRounds = 4'(MAX_ROUNDS);
    localparam logic [3:0] UnrollW   = 4'(UNROLL);

    fsm_e       fsm_q, fsm_d;
    type_state  state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] rounds_done_q, rounds_done_d;
    logic       done_q, done_d;
    logic [3:0] n_eff;
    logic [3:0] step;
    type_state  chain [0:UNROLL];

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round: constant add, bit-sliced S-box, linear diffusion.
    function automatic type_state round_fn(input type_state s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        type_state   r;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, 4'd15 - idx, idx};
        x3 = s[3];
        x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        r[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        r[2] = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
        r[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        r[4] = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
        return r;
    endfunction

    // Unrolled round chain; stages beyond the rounds still owed pass through.
    always_comb begin
        step     = (remaining_q < UnrollW) ? remaining_q : UnrollW;
        chain[0] = state_q;
        for (int j = 0; j < int'(UNROLL); j++) begin
            if (4'(j) < step) begin
                chain[j+1] = round_fn(chain[j], idx_q + 4'(j));
            end else begin
                chain[j+1] = chain[j];
            end
        end
    end

    // Next-state logic: accept in idle, advance or abort in run.
    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        remaining_d   = remaining_q;
        idx_d         = idx_q;
        rounds_done_d = rounds_done_q;
        done_d        = 1'b0;
        n_eff         = (rounds_i == 4'd0 || rounds_i > MaxRounds) ? MaxRounds : rounds_i;
        case (fsm_q)
            StIdle: begin
                // Abort wins over a same-cycle start.
                if (start_i && !abort_i) begin
                    state_d       = state_i;
                    remaining_d   = n_eff;
                    idx_d         = MaxRounds - n_eff;
                    rounds_done_d = 4'd0;
                    fsm_d         = StRun;
                end
            end
            StRun: begin
                if (abort_i) begin
                    fsm_d = StIdle;
                end else begin
                    state_d       = chain[UNROLL];
                    remaining_d   = remaining_q - step;
                    idx_d         = idx_q + step;
                    rounds_done_d = rounds_done_q + step;
                    if (remaining_q == step) begin
                        fsm_d  = StIdle;
                        done_d = 1'b1;
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State and sequencing registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q         <= StIdle;
            state_q       <= '0;
            remaining_q   <= 4'd0;
            idx_q         <= 4'd0;
            rounds_done_q <= 4'd0;
            done_q        <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            idx_q         <= idx_d;
            rounds_done_q <= rounds_done_d;
            done_q        <= done_d;
        end
    end

    assign ready_o       = (fsm_q == StIdle);
    assign busy_o        = (fsm_q == StRun);
    assign done_o        = done_q;
    assign rounds_done_o = rounds_done_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ascon_permutation_core.sv
// Bench for ascon_permutation_core: UNROLL=1 and UNROLL=4 instances share
// stimulus; results are compared against a table-based S-box reference.
module tb_ascon_permutation_core;

    typedef logic [4:0][63:0] type_state;

    typedef struct {
        logic [3:0] rounds;
        type_state  st;
        int         n_eff;
        int         lat1;
        int         lat4;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] rounds;
    type_state  state_in;

    logic       ready1, busy1, done1, ready4, busy4, done4;
    logic [3:0] rd1, rd4;
    type_state  s1, s4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ascon_permutation_core #(.UNROLL(1), .MAX_ROUNDS(12)) u_dut1 (
        .clock_i       (clk),
        .reset_i       (reset),
        .start_i       (start),
        .abort_i       (abort),
        .rounds_i      (rounds),
        .state_i       (state_in),
        .ready_o       (ready1),
        .busy_o        (busy1),
        .done_o        (done1),
        .rounds_done_o (rd1),
        .state_o       (s1)
    );

    ascon_permutation_core #(.UNROLL(4), .MAX_ROUNDS(12)) u_dut4 (
        .clock_i       (clk),
        .reset_i       (reset),
        .start_i       (start),
        .abort_i       (abort),
        .rounds_i      (rounds),
        .state_i       (state_in),
        .ready_o       (ready4),
        .busy_o        (busy4),
        .done_o        (done4),
        .rounds_done_o (rd4),
        .state_o       (s4)
    );

    // Reference S-box as a lookup table, x0 in the MSB of the column.
    function automatic logic [4:0] sbox(input logic [4:0] x);
        case (x)
            5'h00: return 5'h04;  5'h01: return 5'h0b;  5'h02: return 5'h1f;  5'h03: return 5'h14;
            5'h04: return 5'h1a;  5'h05: return 5'h15;  5'h06: return 5'h09;  5'h07: return 5'h02;
            5'h08: return 5'h1b;  5'h09: return 5'h05;  5'h0a: return 5'h08;  5'h0b: return 5'h12;
            5'h0c: return 5'h1d;  5'h0d: return 5'h03;  5'h0e: return 5'h06;  5'h0f: return 5'h1c;
            5'h10: return 5'h1e;  5'h11: return 5'h13;  5'h12: return 5'h07;  5'h13: return 5'h0e;
            5'h14: return 5'h00;  5'h15: return 5'h0d;  5'h16: return 5'h11;  5'h17: return 5'h18;
            5'h18: return 5'h10;  5'h19: return 5'h0c;  5'h1a: return 5'h01;  5'h1b: return 5'h19;
            5'h1c: return 5'h16;  5'h1d: return 5'h0a;  5'h1e: return 5'h0f;  default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic type_state model_round(input type_state s, input int i);
        type_state  t;
        logic [4:0] col, o;
        s[2][7:0] = s[2][7:0] ^ {4'(15 - i), 4'(i)};
        for (int b = 0; b < 64; b++) begin
            col     = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o       = sbox(col);
            t[0][b] = o[4];
            t[1][b] = o[3];
            t[2][b] = o[2];
            t[3][b] = o[1];
            t[4][b] = o[0];
        end
        s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
        s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
        s[2] = t[2] ^ rotr(t[2], 1) ^ rotr(t[2], 6);
        s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
        s[4] = t[4] ^ rotr(t[4], 7) ^ rotr(t[4], 41);
        return s;
    endfunction

    function automatic type_state model_perm(input type_state s, input int n);
        for (int r = 12 - n; r < 12; r++) s = model_round(s, r);
        return s;
    endfunction

    task automatic check_w(input string name, input type_state act, input type_state exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One run on both instances; checks latency, single pulse, result, count, hold.
    task automatic run_vec(input string tag, input vec_t v);
        type_state exp, got1, got4;
        int        at1, at4, cnt1, cnt4, rdn1, rdn4, rdy1, rdy4;
        exp  = model_perm(v.st, v.n_eff);
        at1  = -1; at4 = -1; cnt1 = 0; cnt4 = 0;
        rdn1 = -1; rdn4 = -1; rdy1 = -1; rdy4 = -1;
        got1 = '0; got4 = '0;
        @(negedge clk);
        start = 1'b1; rounds = v.rounds; state_in = v.st;
        @(negedge clk);
        start = 1'b0;
        check_n({tag, " busy1"}, int'(busy1), 1);
        check_n({tag, " busy4"}, int'(busy4), 1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done1) begin
                cnt1++;
                if (cnt1 == 1) begin at1 = c; got1 = s1; rdn1 = int'(rd1); rdy1 = int'(ready1); end
            end
            if (done4) begin
                cnt4++;
                if (cnt4 == 1) begin at4 = c; got4 = s4; rdn4 = int'(rd4); rdy4 = int'(ready4); end
            end
        end
        check_n({tag, " lat1"}, at1, v.lat1);
        check_n({tag, " lat4"}, at4, v.lat4);
        check_n({tag, " pulses1"}, cnt1, 1);
        check_n({tag, " pulses4"}, cnt4, 1);
        check_w({tag, " state1"}, got1, exp);
        check_w({tag, " state4"}, got4, exp);
        check_n({tag, " rdone1"}, rdn1, v.n_eff);
        check_n({tag, " rdone4"}, rdn4, v.n_eff);
        check_n({tag, " ready1@done"}, rdy1, 1);
        check_n({tag, " ready4@done"}, rdy4, 1);
        check_w({tag, " hold1"}, s1, exp);
    endtask

    initial begin
        vec_t      vecs [7];
        type_state st_a, st_b, st_z, exp;
        int        d1cnt, d4cnt, d4at;
        type_state got4;

        st_z = '0;
        st_a = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'hdeadbeefcafef00d,
                64'h0f1e2d3c4b5a6978, 64'h8000000000000001};
        st_b = {64'h5555aaaa3333cccc, 64'h0000000100000002, 64'hffffffffffffffff,
                64'h1234000000005678, 64'h00000000000000ff};

        vecs[0] = '{rounds: 4'd12, st: st_z, n_eff: 12, lat1: 12, lat4: 3};
        vecs[1] = '{rounds: 4'd1,  st: st_z, n_eff: 1,  lat1: 1,  lat4: 1};
        vecs[2] = '{rounds: 4'd6,  st: st_a, n_eff: 6,  lat1: 6,  lat4: 2};
        vecs[3] = '{rounds: 4'd0,  st: st_z, n_eff: 12, lat1: 12, lat4: 3};
        vecs[4] = '{rounds: 4'd15, st: st_z, n_eff: 12, lat1: 12, lat4: 3};
        vecs[5] = '{rounds: 4'd8,  st: st_b, n_eff: 8,  lat1: 8,  lat4: 2};
        vecs[6] = '{rounds: 4'd5,  st: st_a, n_eff: 5,  lat1: 5,  lat4: 2};

        reset = 1'b1; start = 1'b0; abort = 1'b0; rounds = 4'd0; state_in = '0;
        #1;
        check_n("rst ready1", int'(ready1), 1);
        check_n("rst busy1", int'(busy1), 0);
        check_n("rst done1", int'(done1), 0);
        check_n("rst rdone1", int'(rd1), 0);
        check_w("rst state1", s1, st_z);
        check_n("rst ready4", int'(ready4), 1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Abort on the 5th run cycle, with a start attempted while busy.
        d1cnt = 0; d4cnt = 0; d4at = -1; got4 = '0;
        @(negedge clk);
        start = 1'b1; rounds = 4'd12; state_in = st_a;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done1) d1cnt++;
            if (done4) begin
                d4cnt++;
                if (d4cnt == 1) begin d4at = c; got4 = s4; end
            end
            case (c)
                1: begin start = 1'b1; rounds = 4'd1; state_in = st_b; end
                2: begin start = 1'b0; check_n("busy start ignored rdone1", int'(rd1), 2); end
                4: begin check_n("pre-abort rdone1", int'(rd1), 4); abort = 1'b1; end
                5: begin
                    abort = 1'b0;
                    check_n("abort ready1", int'(ready1), 1);
                    check_n("abort busy1", int'(busy1), 0);
                    check_n("abort rdone1", int'(rd1), 4);
                end
                default: ;
            endcase
        end
        check_n("abort no done1", d1cnt, 0);
        check_n("abort u4 pulses", d4cnt, 1);
        check_n("abort u4 lat", d4at, 3);
        check_w("abort u4 state", got4, model_perm(st_a, 12));
        check_n("idle abort rdone4", int'(rd4), 12);

        // Abort and start together in idle: nothing is accepted.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; rounds = 4'd3; state_in = st_b;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_n("abort+start ready1", int'(ready1), 1);
        check_n("abort+start rdone1", int'(rd1), 4);

        // Back-to-back: a start in the done cycle is taken.
        @(negedge clk);
        start = 1'b1; rounds = 4'd3; state_in = st_a;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check_n("b2b first done1", int'(done1), 1);
        check_w("b2b first state1", s1, model_perm(st_a, 3));
        start = 1'b1; rounds = 4'd1; state_in = st_b;
        @(negedge clk);
        start = 1'b0;
        check_n("b2b accepted busy1", int'(busy1), 1);
        check_n("b2b done1 cleared", int'(done1), 0);
        @(negedge clk);
        exp = model_perm(st_b, 1);
        check_n("b2b second done1", int'(done1), 1);
        check_w("b2b second state1", s1, exp);
        check_n("b2b second rdone1", int'(rd1), 1);
        check_n("b2b second done4", int'(done4), 1);
        check_w("b2b second state4", s4, exp);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; rounds = 4'd12; state_in = st_a;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_n("pre-reset busy1", int'(busy1), 1);
        #2 reset = 1'b1;
        #1;
        check_n("async rst ready1", int'(ready1), 1);
        check_n("async rst done1", int'(done1), 0);
        check_n("async rst rdone1", int'(rd1), 0);
        check_w("async rst state1", s1, st_z);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
